// File: rtl/uart_tx_framed.sv
// uart_tx_framed: framed UART transmitter (start, data LSB first, parity, stop).
// Ports: sysclk/rst, DBUS+txd_startH in, tx_ready, txd, txd_doneH out.
module uart_tx_framed #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] DBUS,
  input  logic                 txd_startH,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 txd_doneH
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [15:0] DIV_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] DIV_STOP = 16'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state, state_d;
  logic [15:0]          div, div_d;
  logic [BW-1:0]        bit_cnt, bit_cnt_d;
  logic                 stop_cnt, stop_cnt_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 par, par_d;
  logic                 txd_d, done_d;
  logic                 bit_end, stop_end;

  assign bit_end  = (div == DIV_LAST);
  // The last stop cycle is the IDLE/done cycle, so STOP leaves one
  // cycle early; this lets a back-to-back start follow with no gap.
  assign stop_end = (div == DIV_STOP) && (stop_cnt == STOP_LAST);
  assign tx_ready = (state == IDLE);

  always_comb begin
    state_d    = state;
    div_d      = div + 16'd1;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    shreg_d    = shreg;
    par_d      = par;
    txd_d      = txd;
    done_d     = 1'b0;
    unique case (state)
      IDLE: begin
        div_d = '0;
        txd_d = 1'b1;
        if (txd_startH) begin
          state_d    = START;
          shreg_d    = DBUS;
          par_d      = (^DBUS) ^ 1'(PARITY_ODD);
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          txd_d      = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          div_d   = '0;
          txd_d   = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          div_d = '0;
          if (bit_cnt == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              txd_d   = par;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt + BW'(1);
            shreg_d   = shreg >> 1;
            txd_d     = shreg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          div_d   = '0;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (stop_end) begin
          state_d = IDLE;
          div_d   = '0;
          done_d  = 1'b1;
        end else if (bit_end) begin
          div_d      = '0;
          stop_cnt_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state     <= IDLE;
      div       <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shreg     <= '0;
      par       <= 1'b0;
      txd       <= 1'b1;
      txd_doneH <= 1'b0;
    end else begin
      state     <= state_d;
      div       <= div_d;
      bit_cnt   <= bit_cnt_d;
      stop_cnt  <= stop_cnt_d;
      shreg     <= shreg_d;
      par       <= par_d;
      txd       <= txd_d;
      txd_doneH <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// tb_uart_tx_framed: five parameterisations driven in parallel,
// each checked every cycle against a queue-of-line-levels model.
module tb_uart_tx_framed;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] dbus;
  logic       txd_w  [N];
  logic       rdy_w  [N];
  logic       done_w [N];
  logic       armed = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) if (rst) armed <= 1'b1;

  for (genvar g = 0; g < N; g++) begin : u
    localparam int DB  = (g == 3) ? 7 : ((g == 4) ? 9 : 8);
    localparam int CPB = (g == 4) ? 3 : 4;
    localparam int PE  = (g == 1 || g == 2 || g == 4) ? 1 : 0;
    localparam int PO  = (g == 2 || g == 4) ? 1 : 0;
    localparam int SB  = (g == 3 || g == 4) ? 2 : 1;

    logic o_txd, o_rdy, o_done;
    bit   q[$];

    uart_tx_framed #(
      .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .PARITY_EN(PE),
      .PARITY_ODD(PO), .STOP_BITS(SB)
    ) dut (
      .sysclk(clk), .rst(rst), .DBUS(dbus[DB-1:0]),
      .txd_startH(start), .tx_ready(o_rdy), .txd(o_txd),
      .txd_doneH(o_done)
    );

    assign txd_w[g]  = o_txd;
    assign rdy_w[g]  = o_rdy;
    assign done_w[g] = o_done;

    // Model: on acceptance, queue the line level for every cycle of the
    // frame; the final queued cycle is the done/ready cycle.
    always @(posedge clk) begin
      logic [8:0] dv;
      bit p;
      dv = dbus;
      if (rst) begin
        q.delete();
      end else if (start && q.size() == 0) begin
        repeat (CPB) q.push_back(1'b0);
        p = (PO != 0);
        for (int i = 0; i < DB; i++) begin
          p = p ^ dv[i];
          repeat (CPB) q.push_back(dv[i]);
        end
        if (PE != 0) repeat (CPB) q.push_back(p);
        repeat (SB * CPB) q.push_back(1'b1);
      end
    end

    always @(negedge clk) begin
      bit e_txd, e_done;
      if (armed) begin
        if (q.size() > 0) begin
          e_txd  = q.pop_front();
          e_done = (q.size() == 0);
        end else begin
          e_txd  = 1'b1;
          e_done = 1'b0;
        end
        chk($sformatf("d%0d txd", g), 32'(txd_w[g]), 32'(e_txd));
        chk($sformatf("d%0d done", g), 32'(done_w[g]), 32'(e_done));
        chk($sformatf("d%0d ready", g), 32'(rdy_w[g]),
            32'(q.size() == 0));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [8:0] d);
    dbus  = d;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    dbus  = 9'h1FF;
    cyc(3);
    rst   = 1'b0;
    start = 1'b0;
    cyc(2);

    send(9'h0A5);
    cyc(60);
    send(9'h07F);
    cyc(60);

    dbus  = 9'h001;
    start = 1'b1;
    cyc(2);
    dbus  = 9'h080;
    cyc(100);
    start = 1'b0;
    cyc(60);

    send(9'h0A5);
    cyc(20);
    send(9'h1FF);
    cyc(60);

    send(9'h15A);
    cyc(13);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(3);
    send(9'h0C3);
    cyc(60);

    for (int i = 0; i < 3000; i++) begin
      dbus  = 9'($urandom);
      start = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 249) == 0);
      cyc(1);
    end
    rst   = 1'b0;
    start = 1'b0;
    cyc(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
